// File: rtl/sw_seq_feeder.sv
// Smith-Waterman input feeder: buffers one packed ref/query job, streams it base-by-base,
// then waits for the core's finish pulse. Optional WAIT_FIN watchdog: SW_FEED_TIMEOUT_EN.
module sw_seq_feeder #(
    parameter int LEN_REF     = 64,
    parameter int LEN_QUERY   = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sel,
    input  logic [7:0] in_data,
    output logic       sw_valid,
    output logic [1:0] sw_data_ref,
    output logic [1:0] sw_data_query,
    input  logic       sw_finish,
    output logic       busy,
    output logic       job_done,
    output logic       err_ovf,
    output logic       err_timeout
);
    localparam int NB_REF = LEN_REF / 4;
    localparam int NB_QRY = LEN_QUERY / 4;
    localparam int RB_W   = $clog2(NB_REF);
    localparam int QB_W   = $clog2(NB_QRY);
    localparam int IDX_W  = $clog2(LEN_REF);
    localparam logic [RB_W-1:0]  RB_LAST  = RB_W'(NB_REF - 1);
    localparam logic [QB_W-1:0]  QB_LAST  = QB_W'(NB_QRY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN_REF - 1);

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_FIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_ref_mem [NB_REF];
    logic [7:0]       r_qry_mem [NB_QRY];
    logic [RB_W-1:0]  r_ref_bp;
    logic [QB_W-1:0]  r_qry_bp;
    logic             r_ref_full;
    logic             r_qry_full;
    logic [IDX_W-1:0] r_idx;
    logic             r_in_ready;
    logic             r_sw_valid;
    logic [1:0]       r_sw_data_ref;
    logic [1:0]       r_sw_data_query;
    logic             r_busy;
    logic             r_job_done;
    logic             r_err_ovf;
    logic             r_err_timeout;

    logic       w_accept;
    logic       w_ref_wr;
    logic       w_qry_wr;
    logic       w_ovf;
    logic       w_ref_full_nxt;
    logic       w_qry_full_nxt;
    logic       w_fin;
    logic       w_timeout;
    logic       w_q_in_range;
    logic [7:0] w_ref_byte;
    logic [7:0] w_qry_byte;
    logic [1:0] w_ref_base;
    logic [1:0] w_qry_base;

    assign w_accept       = in_valid & r_in_ready & (r_state == ST_LOAD);
    assign w_ref_wr       = w_accept & ~in_sel & ~r_ref_full;
    assign w_qry_wr       = w_accept & in_sel & ~r_qry_full;
    assign w_ovf          = w_accept & (in_sel ? r_qry_full : r_ref_full);
    assign w_ref_full_nxt = r_ref_full | (w_ref_wr & (r_ref_bp == RB_LAST));
    assign w_qry_full_nxt = r_qry_full | (w_qry_wr & (r_qry_bp == QB_LAST));
    assign w_fin          = (r_state == ST_WAIT_FIN) & sw_finish;

    // Base i lives in byte i/4 at bit offset 2*(i%4); query is zero beyond its length.
    assign w_ref_byte   = r_ref_mem[r_idx[IDX_W-1:2]];
    assign w_qry_byte   = r_qry_mem[r_idx[QB_W+1:2]];
    assign w_ref_base   = w_ref_byte[{r_idx[1:0], 1'b0} +: 2];
    assign w_qry_base   = w_qry_byte[{r_idx[1:0], 1'b0} +: 2];
    assign w_q_in_range = (LEN_QUERY >= LEN_REF) ? 1'b1 : (r_idx < IDX_W'(LEN_QUERY));

`ifdef SW_FEED_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] r_wait_cnt;

    // Watchdog counter: counts cycles spent in WAIT_FIN, idle elsewhere.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT_FIN) begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // A finish on the expiry cycle wins over the timeout.
    assign w_timeout = (r_state == ST_WAIT_FIN) & ~sw_finish & (r_wait_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
    if (TIMEOUT_CYC < 1) begin : g_cfg_bad_timeout
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_ref_full_nxt & w_qry_full_nxt) begin
                    w_state_nxt = ST_STREAM;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_STREAM: begin
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_WAIT_FIN;
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_WAIT_FIN: begin
                if (w_fin | w_timeout) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_WAIT_FIN;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // Write pointers and full flags; cleared whenever not loading.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ref_bp   <= '0;
            r_qry_bp   <= '0;
            r_ref_full <= 1'b0;
            r_qry_full <= 1'b0;
        end else if (r_state != ST_LOAD) begin
            r_ref_bp   <= '0;
            r_qry_bp   <= '0;
            r_ref_full <= 1'b0;
            r_qry_full <= 1'b0;
        end else begin
            if (w_ref_wr) begin
                r_ref_bp   <= (r_ref_bp == RB_LAST) ? '0 : r_ref_bp + RB_W'(1);
                r_ref_full <= (r_ref_bp == RB_LAST);
            end
            if (w_qry_wr) begin
                r_qry_bp   <= (r_qry_bp == QB_LAST) ? '0 : r_qry_bp + QB_W'(1);
                r_qry_full <= (r_qry_bp == QB_LAST);
            end
        end
    end

    // Sequence storage; contents are don't-care until rewritten by the next job.
    always_ff @(posedge clk) begin
        if (w_ref_wr) begin
            r_ref_mem[r_ref_bp] <= in_data;
        end
        if (w_qry_wr) begin
            r_qry_mem[r_qry_bp] <= in_data;
        end
    end

    // Stream index and SW core drive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx           <= '0;
            r_sw_valid      <= 1'b0;
            r_sw_data_ref   <= 2'b00;
            r_sw_data_query <= 2'b00;
        end else if (r_state == ST_STREAM) begin
            r_idx           <= r_idx + IDX_W'(1);
            r_sw_valid      <= 1'b1;
            r_sw_data_ref   <= w_ref_base;
            r_sw_data_query <= w_q_in_range ? w_qry_base : 2'b00;
        end else begin
            r_idx           <= '0;
            r_sw_valid      <= 1'b0;
            r_sw_data_ref   <= 2'b00;
            r_sw_data_query <= 2'b00;
        end
    end

    // Host handshake, status pulse and sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
            r_job_done    <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_in_ready    <= (w_state_nxt == ST_LOAD);
            r_busy        <= (w_state_nxt != ST_LOAD);
            r_job_done    <= w_fin;
            r_err_ovf     <= r_err_ovf | w_ovf;
            r_err_timeout <= r_err_timeout | w_timeout;
        end
    end

    assign in_ready      = r_in_ready;
    assign sw_valid      = r_sw_valid;
    assign sw_data_ref   = r_sw_data_ref;
    assign sw_data_query = r_sw_data_query;
    assign busy          = r_busy;
    assign job_done      = r_job_done;
    assign err_ovf       = r_err_ovf;
    assign err_timeout   = r_err_timeout;
endmodule

// File: tb/tb_sw_seq_feeder.sv
// Scoreboard bench for sw_seq_feeder: expected stream pushed at load, popped on sw_valid.
module tb_sw_seq_feeder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sel = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sw_valid;
    logic [1:0] sw_data_ref;
    logic [1:0] sw_data_query;
    logic       sw_finish = 1'b0;
    logic       busy;
    logic       job_done;
    logic       err_ovf;
    logic       err_timeout;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    logic [7:0] ref_b [16];
    logic [7:0] qry_b [8];
    logic [3:0] sb [$];

    sw_seq_feeder #(.LEN_REF(64), .LEN_QUERY(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .sw_valid(sw_valid),
        .sw_data_ref(sw_data_ref), .sw_data_query(sw_data_query),
        .sw_finish(sw_finish), .busy(busy), .job_done(job_done),
        .err_ovf(err_ovf), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Stream monitor: every valid beat must match the next scoreboard entry.
    always @(negedge clk) begin
        if (sw_valid) begin
            logic [3:0] exp_v;
            checks++;
            valid_cnt++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL stream_extra: got ref=%0d qry=%0d, none expected", sw_data_ref, sw_data_query);
            end else begin
                exp_v = sb.pop_front();
                if ({sw_data_ref, sw_data_query} !== exp_v) begin
                    failures++;
                    $display("FAIL stream_data: got ref=%0d qry=%0d, expected ref=%0d qry=%0d",
                             sw_data_ref, sw_data_query, exp_v[3:2], exp_v[1:0]);
                end
            end
        end
    end

    task automatic push_expected();
        logic [7:0] rb, qb;
        logic [1:0] er, eq;
        sb.delete();
        valid_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            rb = ref_b[i / 4] >> (2 * (i % 4));
            er = rb[1:0];
            if (i < 32) begin
                qb = qry_b[i / 4] >> (2 * (i % 4));
                eq = qb[1:0];
            end else begin
                eq = 2'd0;
            end
            sb.push_back({er, eq});
        end
    endtask

    task automatic send_byte(input logic sel, input logic [7:0] d);
        in_sel = sel;
        in_data = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_contig(input logic [7:0] rv, input logic [7:0] qv);
        for (int k = 0; k < 16; k++) ref_b[k] = rv;
        for (int k = 0; k < 8; k++) qry_b[k] = qv;
        push_expected();
        for (int k = 0; k < 16; k++) send_byte(1'b0, ref_b[k]);
        for (int k = 0; k < 8; k++) send_byte(1'b1, qry_b[k]);
    endtask

    task automatic pulse_finish();
        sw_finish = 1'b1;
        @(posedge clk); #1;
        sw_finish = 1'b0;
    endtask

    task automatic wait_stream_end(output bit ok);
        bit seen = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (sw_valid) seen = 1'b1;
            else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, sw_valid, busy, job_done, err_ovf, err_timeout} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy/val/busy/done/ovf/to=%b, expected 100000",
                     {in_ready, sw_valid, busy, job_done, err_ovf, err_timeout});
        end
        checks++;
        if ({sw_data_ref, sw_data_query} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_data: got %b, expected 0000", {sw_data_ref, sw_data_query});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        load_contig(8'h1B, 8'hE4);
        @(negedge clk);
        checks++;
        if ({busy, in_ready, sw_valid} !== 3'b100) begin
            failures++;
            $display("FAIL basic_entry: got busy/rdy/val=%b, expected 100", {busy, in_ready, sw_valid});
        end
        wait_stream_end(ok);
        checks++;
        if (!ok || valid_cnt != 64 || sb.size() != 0) begin
            failures++;
            $display("FAIL basic_len: got valid_cycles=%0d left=%0d done=%0d, expected 64 0 1",
                     valid_cnt, sb.size(), ok);
        end
        checks++;
        if ({busy, in_ready, job_done} !== 3'b100) begin
            failures++;
            $display("FAIL basic_wait: got busy/rdy/done=%b, expected 100", {busy, in_ready, job_done});
        end
        pulse_finish();
        @(negedge clk);
        checks++;
        if ({job_done, in_ready, busy} !== 3'b110) begin
            failures++;
            $display("FAIL basic_done: got done/rdy/busy=%b, expected 110", {job_done, in_ready, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_interleaved();
        bit ok;
        for (int k = 0; k < 16; k++) ref_b[k] = 8'($urandom);
        for (int k = 0; k < 8; k++) qry_b[k] = 8'($urandom);
        push_expected();
        for (int k = 0; k < 8; k++) begin
            send_byte(1'b0, ref_b[k]);
            if (k % 3 == 0) begin
                @(posedge clk); #1;
            end
            send_byte(1'b1, qry_b[k]);
        end
        for (int k = 8; k < 16; k++) begin
            send_byte(1'b0, ref_b[k]);
            if (k % 4 == 1) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, in_ready, sw_valid} !== 3'b100) begin
            failures++;
            $display("FAIL ilv_entry: got busy/rdy/val=%b, expected 100", {busy, in_ready, sw_valid});
        end
        @(negedge clk);
        checks++;
        if (sw_valid !== 1'b1) begin
            failures++;
            $display("FAIL ilv_first_valid: got %b, expected 1", sw_valid);
        end
        wait_stream_end(ok);
        checks++;
        if (!ok || valid_cnt != 64 || sb.size() != 0) begin
            failures++;
            $display("FAIL ilv_len: got valid_cycles=%0d left=%0d, expected 64 0", valid_cnt, sb.size());
        end
        pulse_finish();
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        bit ok;
        for (int k = 0; k < 16; k++) ref_b[k] = 8'($urandom);
        ref_b[0] = 8'h00;
        for (int k = 0; k < 8; k++) qry_b[k] = 8'($urandom);
        push_expected();
        for (int k = 0; k < 16; k++) send_byte(1'b0, ref_b[k]);
        @(negedge clk);
        checks++;
        if (err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_early: got %b, expected 0", err_ovf);
        end
        #1 send_byte(1'b0, 8'hFF);
        @(negedge clk);
        checks++;
        if ({err_ovf, busy, in_ready} !== 3'b101) begin
            failures++;
            $display("FAIL ovf_set: got ovf/busy/rdy=%b, expected 101", {err_ovf, busy, in_ready});
        end
        #1;
        for (int k = 0; k < 8; k++) send_byte(1'b1, qry_b[k]);
        wait_stream_end(ok);
        checks++;
        if (!ok || valid_cnt != 64 || sb.size() != 0) begin
            failures++;
            $display("FAIL ovf_len: got valid_cycles=%0d left=%0d, expected 64 0", valid_cnt, sb.size());
        end
        pulse_finish();
        @(negedge clk);
        checks++;
        if (err_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %b, expected 1", err_ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_finish();
        bit ok;
        int pulses = 0;
        load_contig(8'h6C, 8'h93);
        repeat (20) @(negedge clk);
        #1 pulse_finish();
        @(negedge clk);
        checks++;
        if ({job_done, busy, sw_valid} !== 3'b011) begin
            failures++;
            $display("FAIL fin_ignored: got done/busy/val=%b, expected 011", {job_done, busy, sw_valid});
        end
        wait_stream_end(ok);
        checks++;
        if (!ok || valid_cnt != 64 || sb.size() != 0) begin
            failures++;
            $display("FAIL fin_len: got valid_cycles=%0d left=%0d, expected 64 0", valid_cnt, sb.size());
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({job_done, busy} !== 2'b01) begin
            failures++;
            $display("FAIL fin_hold: got done/busy=%b, expected 01", {job_done, busy});
        end
        #1 pulse_finish();
        @(negedge clk);
        checks++;
        if ({job_done, in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL fin_done: got done/rdy=%b, expected 11", {job_done, in_ready});
        end
        for (int c = 0; c < 5; c++) begin
            if (job_done) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL fin_once: got %0d pulses, expected 1", pulses);
        end
        #1 load_contig(8'hD2, 8'h4B);
        wait_stream_end(ok);
        checks++;
        if (!ok || valid_cnt != 64 || sb.size() != 0) begin
            failures++;
            $display("FAIL fin_second: got valid_cycles=%0d left=%0d, expected 64 0", valid_cnt, sb.size());
        end
        pulse_finish();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        bit ok;
        bit hit = 1'b0;
        load_contig(8'hA5, 8'h3C);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (valid_cnt == 10) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rst_mid_reach: got valid_cycles=%0d, expected 10", valid_cnt);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({sw_valid, busy, in_ready, err_ovf} !== 4'b0010) begin
            failures++;
            $display("FAIL rst_mid_state: got val/busy/rdy/ovf=%b, expected 0010",
                     {sw_valid, busy, in_ready, err_ovf});
        end
        #1 load_contig(8'h27, 8'hB1);
        wait_stream_end(ok);
        checks++;
        if (!ok || valid_cnt != 64 || sb.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_fresh: got valid_cycles=%0d left=%0d, expected 64 0", valid_cnt, sb.size());
        end
        pulse_finish();
        @(posedge clk); #1;
    endtask

`ifdef SW_FEED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int pulses = 0;
        load_contig(8'h55, 8'hAA);
        wait_stream_end(ok);
        repeat (14) @(negedge clk);
        checks++;
        if ({err_timeout, busy} !== 2'b01) begin
            failures++;
            $display("FAIL to_early: got to/busy=%b, expected 01", {err_timeout, busy});
        end
        @(negedge clk);
        checks++;
        if ({err_timeout, in_ready, busy, job_done} !== 4'b1100) begin
            failures++;
            $display("FAIL to_fire: got to/rdy/busy/done=%b, expected 1100",
                     {err_timeout, in_ready, busy, job_done});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (job_done) pulses++;
        end
        checks++;
        if (pulses != 0 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky: got pulses=%0d to=%b, expected 0 1", pulses, err_timeout);
        end
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_interleaved();
        test_overflow();
        test_finish();
        test_reset_midstream();
`ifdef SW_FEED_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
